// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register with 1-entry skid buffer, stall/flush control and decode field split.
// Optional performance counters are built only when IF_ID_PERF_EN is defined.
module if_id_stage_reg #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int unsigned PC_INC    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instr,
    input  logic        id_stall,
    input  logic        flush,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic [5:0]  id_opcode,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [4:0]  id_shamt,
    output logic [5:0]  id_funct,
    output logic [15:0] id_imm,
    output logic [25:0] id_jaddr,
    output logic [31:0] perf_stall_cycles,
    output logic [15:0] perf_flushes
);

    logic        main_valid_q, main_valid_d;
    logic [31:0] main_instr_q, main_instr_d;
    logic [31:0] main_pc4_q, main_pc4_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;
    logic        accept;
    logic [31:0] in_pc4;

    // Ready depends on registered state only, so ID stall never reaches IF combinationally.
    assign if_ready = ~skid_valid_q;
    assign accept   = if_valid & if_ready;
    assign in_pc4   = if_pc + 32'(PC_INC);

    always_comb begin
        main_valid_d = main_valid_q;
        main_instr_d = main_instr_q;
        main_pc4_d   = main_pc4_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        if (flush) begin
            main_valid_d = 1'b0;
            main_instr_d = NOP_INSTR;
            skid_valid_d = 1'b0;
        end else if (!id_stall) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_instr_d = skid_instr_q;
                main_pc4_d   = skid_pc4_q;
                skid_valid_d = accept;
                if (accept) begin
                    skid_instr_d = if_instr;
                    skid_pc4_d   = in_pc4;
                end
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_instr_d = if_instr;
                main_pc4_d   = in_pc4;
            end else begin
                main_valid_d = 1'b0;
                main_instr_d = NOP_INSTR;
            end
        end else if (accept) begin
            // Stalled: an empty main slot absorbs the beat, otherwise it parks in the skid.
            if (!main_valid_q) begin
                main_valid_d = 1'b1;
                main_instr_d = if_instr;
                main_pc4_d   = in_pc4;
            end else begin
                skid_valid_d = 1'b1;
                skid_instr_d = if_instr;
                skid_pc4_d   = in_pc4;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_instr_q <= NOP_INSTR;
            main_pc4_q   <= 32'h0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc4_q   <= 32'h0;
        end else begin
            main_valid_q <= main_valid_d;
            main_instr_q <= main_instr_d;
            main_pc4_q   <= main_pc4_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

    assign id_valid    = main_valid_q;
    assign id_instr    = main_instr_q;
    assign id_pc_plus4 = main_pc4_q;
    assign id_opcode   = main_instr_q[31:26];
    assign id_rs       = main_instr_q[25:21];
    assign id_rt       = main_instr_q[20:16];
    assign id_rd       = main_instr_q[15:11];
    assign id_shamt    = main_instr_q[10:6];
    assign id_funct    = main_instr_q[5:0];
    assign id_imm      = main_instr_q[15:0];
    assign id_jaddr    = main_instr_q[25:0];

`ifdef IF_ID_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'h0;
            flush_cnt_q <= 16'h0;
        end else begin
            if (id_stall && main_valid_q && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush && (main_valid_q || skid_valid_q) && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign perf_stall_cycles = stall_cnt_q;
    assign perf_flushes      = flush_cnt_q;
`else
    assign perf_stall_cycles = 32'h0;
    assign perf_flushes      = 16'h0;
`endif

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Bench for if_id_stage_reg: directed steps plus random traffic against a 2-deep FIFO model.
// The stage is modelled as an ordered queue whose head is what ID sees.
module tb_if_id_stage_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_valid = 1'b0;
    logic        if_ready;
    logic [31:0] if_pc = 32'h0;
    logic [31:0] if_instr = 32'h0;
    logic        id_stall = 1'b0;
    logic        flush = 1'b0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [4:0]  id_shamt;
    logic [5:0]  id_funct;
    logic [15:0] id_imm;
    logic [25:0] id_jaddr;
    logic [31:0] perf_stall_cycles;
    logic [15:0] perf_flushes;

    int compared = 0;
    int mismatched = 0;

    // Reference model state
    logic [31:0] q_instr[$];
    logic [31:0] q_pc4[$];
    logic [31:0] last_pc4 = 32'h0;
    logic [31:0] m_stall_cnt = 32'h0;
    logic [15:0] m_flush_cnt = 16'h0;

    always #5 clk = ~clk;

    if_id_stage_reg dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_valid         (if_valid),
        .if_ready         (if_ready),
        .if_pc            (if_pc),
        .if_instr         (if_instr),
        .id_stall         (id_stall),
        .flush            (flush),
        .id_valid         (id_valid),
        .id_instr         (id_instr),
        .id_pc_plus4      (id_pc_plus4),
        .id_opcode        (id_opcode),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_rd            (id_rd),
        .id_shamt         (id_shamt),
        .id_funct         (id_funct),
        .id_imm           (id_imm),
        .id_jaddr         (id_jaddr),
        .perf_stall_cycles(perf_stall_cycles),
        .perf_flushes     (perf_flushes)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_instr.delete();
        q_pc4.delete();
        last_pc4    = 32'h0;
        m_stall_cnt = 32'h0;
        m_flush_cnt = 16'h0;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] ei;
        ei = (q_instr.size() > 0) ? q_instr[0] : 32'h0;
        check({tag, ".valid"}, {31'h0, id_valid}, {31'h0, q_instr.size() > 0});
        check({tag, ".instr"}, id_instr, ei);
        check({tag, ".pc4"}, id_pc_plus4, last_pc4);
        check({tag, ".ready"}, {31'h0, if_ready}, {31'h0, q_instr.size() < 2});
        check({tag, ".fields"}, {id_opcode, id_rs, id_rt, id_rd, id_shamt, id_funct}, ei);
        check({tag, ".imm"}, {16'h0, id_imm}, {16'h0, ei[15:0]});
        check({tag, ".jaddr"}, {6'h0, id_jaddr}, {6'h0, ei[25:0]});
`ifdef IF_ID_PERF_EN
        check({tag, ".pstall"}, perf_stall_cycles, m_stall_cnt);
        check({tag, ".pflush"}, {16'h0, perf_flushes}, {16'h0, m_flush_cnt});
`else
        check({tag, ".pstall0"}, perf_stall_cycles, 32'h0);
        check({tag, ".pflush0"}, {16'h0, perf_flushes}, 32'h0);
`endif
    endtask

    // Drive one cycle, advance the model over the edge, then check after the edge.
    task automatic cycle(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] ins, input logic st, input logic fl,
                         output logic acc);
        logic nonempty;
        if_valid = v;
        if_pc    = pc;
        if_instr = ins;
        id_stall = st;
        flush    = fl;
        acc      = v && (q_instr.size() < 2);
        nonempty = q_instr.size() > 0;
        @(posedge clk);
        if (st && nonempty && !fl && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
        if (fl && nonempty && m_flush_cnt != 16'hFFFF) m_flush_cnt++;
        if (fl) begin
            q_instr.delete();
            q_pc4.delete();
        end else begin
            if (!st && q_instr.size() > 0) begin
                void'(q_instr.pop_front());
                void'(q_pc4.pop_front());
            end
            if (acc) begin
                q_instr.push_back(ins);
                q_pc4.push_back(pc + 32'd4);
            end
        end
        if (q_instr.size() > 0) last_pc4 = q_pc4[0];
        #1;
        check_all(tag);
    endtask

    initial begin
        logic        acc;
        logic        pv;
        logic [31:0] ppc;
        logic [31:0] pins;

        // Reset state while held in reset
        #3;
        check_all("reset");
        #9 rst_n = 1'b1;

        // Reset then stream
        cycle("s1", 1'b1, 32'h0040_0000, 32'h2008_FFFF, 1'b0, 1'b0, acc);
        check("s1.imm_lit", {16'h0, id_imm}, 32'h0000_FFFF);
        check("s1.rt_lit", {27'h0, id_rt}, 32'd8);
        check("s1.op_lit", {26'h0, id_opcode}, 32'h8);
        check("s1.pc4_lit", id_pc_plus4, 32'h0040_0004);

        // Back-to-back stream
        cycle("b2b0", 1'b1, 32'h0040_0004, 32'h0109_5020, 1'b0, 1'b0, acc);
        cycle("b2b1", 1'b1, 32'h0040_0008, 32'h8D2A_0010, 1'b0, 1'b0, acc);
        cycle("b2b2", 1'b1, 32'h0040_000C, 32'h0800_0100, 1'b0, 1'b0, acc);
        cycle("b2b3", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);

        // Stall while streaming A, B, C: IF keeps presenting a beat until it is taken
        cycle("stA", 1'b1, 32'h0000_1000, 32'hAAAA_0001, 1'b0, 1'b0, acc);
        cycle("stB", 1'b1, 32'h0000_1004, 32'hBBBB_0002, 1'b1, 1'b0, acc);
        check("stB.ready_lit", {31'h0, if_ready}, 32'h0);
        cycle("stC0", 1'b1, 32'h0000_1008, 32'hCCCC_0003, 1'b1, 1'b0, acc);
        cycle("stC1", 1'b1, 32'h0000_1008, 32'hCCCC_0003, 1'b1, 1'b0, acc);
        check("stC1.held_lit", id_instr, 32'hAAAA_0001);
        cycle("rel0", 1'b1, 32'h0000_1008, 32'hCCCC_0003, 1'b0, 1'b0, acc);
        check("rel0.B_lit", id_instr, 32'hBBBB_0002);
        cycle("rel1", 1'b1, 32'h0000_1008, 32'hCCCC_0003, 1'b0, 1'b0, acc);
        check("rel1.C_lit", id_instr, 32'hCCCC_0003);
        cycle("rel2", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);

        // Flush with stall and pending skid beat
        cycle("fl0", 1'b1, 32'h0000_2000, 32'h1111_1111, 1'b0, 1'b0, acc);
        cycle("fl1", 1'b1, 32'h0000_2004, 32'h2222_2222, 1'b1, 1'b0, acc);
        cycle("fl2", 1'b1, 32'h0000_2008, 32'h3333_3333, 1'b1, 1'b1, acc);
        check("fl2.valid_lit", {31'h0, id_valid}, 32'h0);
        check("fl2.instr_lit", id_instr, 32'h0);
        check("fl2.ready_lit", {31'h0, if_ready}, 32'h1);
        cycle("fl3", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);

        // PC wrap
        cycle("wrap", 1'b1, 32'hFFFF_FFFC, 32'h0000_000C, 1'b0, 1'b0, acc);
        check("wrap.pc4_lit", id_pc_plus4, 32'h0);

        // Async reset mid-stall with skid full
        cycle("ar0", 1'b1, 32'h0000_3000, 32'h4444_4444, 1'b1, 1'b0, acc);
        cycle("ar1", 1'b1, 32'h0000_3004, 32'h5555_5555, 1'b1, 1'b0, acc);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        #1 rst_n = 1'b1;

        // Two stalled valid cycles after reset
        cycle("pc0", 1'b1, 32'h0000_4000, 32'h6666_6666, 1'b0, 1'b0, acc);
        cycle("pc1", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
        cycle("pc2", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
`ifdef IF_ID_PERF_EN
        check("pc2.stall_lit", perf_stall_cycles, 32'd2);
`endif

        // Random traffic; an unaccepted beat is re-presented unchanged
        pv   = 1'b0;
        ppc  = 32'h0;
        pins = 32'h0;
        for (int i = 0; i < 400; i++) begin
            if (!pv) begin
                pv   = ($urandom_range(0, 3) != 0);
                ppc  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                pins = $urandom;
            end
            cycle("rnd", pv, ppc, pins, ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 11) == 0), acc);
            if (acc || !pv) pv = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
